// File: rtl/pll_reset_seq.sv
// Reset and lock sequencer for the board PLL: pulses pll_rst, waits for a stable
// lock, then releases sys_rst; retries on timeout or lock loss.
module pll_reset_seq #(
    parameter int RST_PULSE    = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [3:0] retries,
    output logic       lost_lock
);

    localparam int MAXP = (RST_PULSE > LOCK_STABLE)
                        ? ((RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT)
                        : ((LOCK_STABLE > LOCK_TIMEOUT) ? LOCK_STABLE : LOCK_TIMEOUT);
    localparam int CW = (MAXP > 1) ? $clog2(MAXP) : 1;

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RESET,
        S_WAIT,
        S_STABLE,
        S_RUN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sync1;
    logic          lock_s;

    // locked is asynchronous to clkin; only lock_s is used past this point
    always_ff @(posedge clkin) begin
        if (rst) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= locked;
            lock_s <= sync1;
        end
    end

    // Outputs are updated on the transition that enters each state so they
    // always come straight from flops and match the state register
    always_ff @(posedge clkin) begin
        if (rst) begin
            state     <= S_RESET;
            cnt       <= '0;
            retries   <= 4'd0;
            lost_lock <= 1'b0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    if (cnt == RST_LAST) begin
                        state   <= S_WAIT;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (lock_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state   <= S_RESET;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        if (retries != 4'd15) begin
                            retries <= retries + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state   <= S_RUN;
                        cnt     <= '0;
                        sys_rst <= 1'b0;
                        ready   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state     <= S_RESET;
                        cnt       <= '0;
                        pll_rst   <= 1'b1;
                        sys_rst   <= 1'b1;
                        ready     <= 1'b0;
                        lost_lock <= 1'b1;
                        if (retries != 4'd15) begin
                            retries <= retries + 4'd1;
                        end
                    end
                end
                default: begin
                    state   <= S_RESET;
                    cnt     <= '0;
                    pll_rst <= 1'b1;
                    sys_rst <= 1'b1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with small parameters, followed by random
// lock/loss events that check the output invariants every cycle.
module tb_pll_reset_seq;

    logic       clkin;
    logic       rst;
    logic       locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [3:0] retries;
    logic       lost_lock;

    int checks   = 0;
    int failures = 0;

    pll_reset_seq #(
        .RST_PULSE    (4),
        .LOCK_STABLE  (8),
        .LOCK_TIMEOUT (32)
    ) dut (
        .clkin     (clkin),
        .rst       (rst),
        .locked    (locked),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .retries   (retries),
        .lost_lock (lost_lock)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    function automatic logic [7:0] packExp(input logic p, input logic s, input logic r,
                                           input logic [3:0] ret, input logic l);
        return {p, s, r, ret, l};
    endfunction

    task automatic applyStimulus(input logic r, input logic l, input int n);
        rst    = r;
        locked = l;
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Fields are packed as {pll_rst, sys_rst, ready, retries, lost_lock}
    initial begin
        logic [3:0] prevRet;
        logic [3:0] curRet;
        int         gap;

        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("reset_values", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(1, 1, 0, 4'd0, 0));
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("rst_pulse_hi", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(1, 1, 0, 4'd0, 0));
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("rst_pulse_lo", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(0, 1, 0, 4'd0, 0));
        applyStimulus(1'b0, 1'b0, 9);
        applyStimulus(1'b0, 1'b1, 10);
        checkOutput("lock_early", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(0, 1, 0, 4'd0, 0));
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("lock_ready", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(0, 0, 1, 4'd0, 0));

        applyStimulus(1'b0, 1'b1, 3);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("loss_pre", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(0, 0, 1, 4'd0, 0));
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("loss_reset", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(1, 1, 0, 4'd1, 1));
        applyStimulus(1'b0, 1'b1, 4);
        checkOutput("reseq_wait", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(0, 1, 0, 4'd1, 1));
        applyStimulus(1'b0, 1'b1, 8);
        checkOutput("reseq_stable", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(0, 1, 0, 4'd1, 1));
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("reseq_ready", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(0, 0, 1, 4'd1, 1));

        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("rst_in_run", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(1, 1, 0, 4'd0, 0));

        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("glitch_wait", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(0, 1, 0, 4'd0, 0));
        applyStimulus(1'b0, 1'b1, 5);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 5);
        checkOutput("glitch_norun", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(0, 1, 0, 4'd0, 0));
        applyStimulus(1'b0, 1'b1, 5);
        checkOutput("glitch_late", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(0, 1, 0, 4'd0, 0));
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("glitch_run", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(0, 0, 1, 4'd0, 0));

        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("rst_again", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(1, 1, 0, 4'd0, 0));
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("to_first_hi", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(1, 1, 0, 4'd0, 0));
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("to_first_lo", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(0, 1, 0, 4'd0, 0));

        // Each timeout period is 4 + 32 = 36 cycles; retries saturates at 15
        for (int k = 1; k <= 16; k++) begin
            prevRet = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
            curRet  = (k > 15) ? 4'd15 : 4'(k);
            applyStimulus(1'b0, 1'b0, 31);
            checkOutput("to_wait_end", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(0, 1, 0, prevRet, 0));
            applyStimulus(1'b0, 1'b0, 1);
            checkOutput("to_retry", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(1, 1, 0, curRet, 0));
            applyStimulus(1'b0, 1'b0, 3);
            checkOutput("to_pulse", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(1, 1, 0, curRet, 0));
            applyStimulus(1'b0, 1'b0, 1);
            checkOutput("to_release", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(0, 1, 0, curRet, 0));
        end

        applyStimulus(1'b0, 1'b1, 5);
        checkOutput("stable_pre_rst", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(0, 1, 0, 4'd15, 0));
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("rst_in_stable", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(1, 1, 0, 4'd0, 0));
        applyStimulus(1'b0, 1'b1, 4);
        checkOutput("post_rst_wait", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(0, 1, 0, 4'd0, 0));
        applyStimulus(1'b0, 1'b1, 8);
        checkOutput("post_rst_stable", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(0, 1, 0, 4'd0, 0));
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("post_rst_run", {pll_rst, sys_rst, ready, retries, lost_lock}, packExp(0, 0, 1, 4'd0, 0));

        // Random-phase lock toggles with per-cycle invariant checks
        for (int ev = 0; ev < 1000; ev++) begin
            gap = int'($urandom_range(60, 1));
            for (int c = 0; c < gap; c++) begin
                @(posedge clkin);
                #1;
                checkOutput("inv_ready", {7'd0, ready}, {7'd0, !sys_rst});
                checkOutput("inv_order", {7'd0, pll_rst & !sys_rst}, 8'd0);
            end
            #($urandom_range(8, 0));
            locked = ~locked;
        end

        @(posedge clkin);
        #1;
        applyStimulus(1'b0, 1'b1, 40);
        checkOutput("final_run", {5'd0, pll_rst, sys_rst, ready}, {5'd0, 3'b001});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
